// File: rtl/de4_qsys_pio_pkg.sv
// de4_qsys_pio_pkg
//   Register address map shared by the PIO slaves on the DE4 Qsys bus.
//   Ports: none (package).
package de4_qsys_pio_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/de4_qsys_blink_timer.sv
// de4_qsys_blink_timer
//   Blink prescaler. Counts 0..period and toggles phase on each wrap, so one
//   half-period lasts period+1 cycles. period == 0 parks the timer with
//   phase = 1 (LEDs lit). load restarts the timer at phase 1.
//   Ports:
//     clk     system clock
//     reset   asynchronous active-high reset
//     period  current half-period minus one (0 = blink off)
//     load    period register is being written this cycle
//     phase   registered blink phase (1 = on, 0 = masked off)
module de4_qsys_blink_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] period,
  input  logic             load,
  output logic             phase
);

  logic [DIV_W-1:0] counter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
      phase   <= 1'b1;
    end else if (load) begin
      // a period write wins over a wrap in the same cycle
      counter <= '0;
      phase   <= 1'b1;
    end else if (period == '0) begin
      counter <= '0;
      phase   <= 1'b1;
    end else if (counter == period) begin
      counter <= '0;
      phase   <= ~phase;
    end else begin
      counter <= counter + 1'b1;
    end
  end

endmodule

// File: rtl/de4_qsys_led_pio.sv
// de4_qsys_led_pio
//   Avalon-MM output PIO for the LED bank: data register with atomic
//   set/clear, per-bit hardware blink mask and blink period, registered
//   read data (latency 1) and registered LED drive.
//   Ports:
//     clk         system clock
//     reset       asynchronous active-high reset
//     address     register select (see de4_qsys_pio_pkg)
//     chipselect  slave select
//     write_n     active-low write strobe, qualified by chipselect
//     writedata   write data, upper unused bits ignored
//     readdata    registered read data, unused upper bits zero
//     out_port    registered LED drive
module de4_qsys_led_pio
  import de4_qsys_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               DIV_W       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] blink_en;
  logic [DIV_W-1:0] period;
  logic             phase;
  logic             wr_en;
  logic             period_load;
  logic [31:0]      rd_next;
  logic             unused_wd;

  assign wr_en       = chipselect && !write_n;
  assign period_load = wr_en && (address == ADDR_PERIOD);
  assign unused_wd   = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data     <= RESET_VALUE;
      blink_en <= '0;
      period   <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data     <= writedata[WIDTH-1:0];
        ADDR_BLINK_EN: blink_en <= writedata[WIDTH-1:0];
        ADDR_PERIOD:   period   <= writedata[DIV_W-1:0];
        ADDR_OUTSET:   data     <= data | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR: data     <= data & ~writedata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  de4_qsys_blink_timer #(
    .DIV_W (DIV_W)
  ) u_blink_timer (
    .clk    (clk),
    .reset  (reset),
    .period (period),
    .load   (period_load),
    .phase  (phase)
  );

  // Read mux sees the pre-write register values, so a read concurrent with
  // a write to the same register returns the old contents.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next[WIDTH-1:0] = data;
      ADDR_BLINK_EN: rd_next[WIDTH-1:0] = blink_en;
      ADDR_PERIOD:   rd_next[DIV_W-1:0] = period;
      ADDR_STATUS:   rd_next[0]         = phase;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      readdata <= rd_next;
      // blink-enabled bits are dark while phase is 0
      out_port <= data & ~(blink_en & {WIDTH{~phase}});
    end
  end

endmodule

// File: tb/tb_de4_qsys_led_pio.sv
module tb_de4_qsys_led_pio;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd_q[$];
  logic [7:0]  out_q[$];

  de4_qsys_led_pio #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .DIV_W       (24)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    logic [7:0]  eo;
    write_reg(3'd0, 32'h12);
    write_reg(3'd1, 32'hFF);
    write_reg(3'd2, 32'h2);
    repeat (5) step();
    #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if (out_port !== 8'hA5) begin
      n_fail++;
      $display("FAIL reset_out_port: got %h want %h", out_port, 8'hA5);
    end
    n_tests++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0);
    end
    step();
    reset = 1'b0;
    address = 3'd3;
    rd_q.push_back(32'h1);
    step();
    e = rd_q.pop_front();
    n_tests++;
    if (readdata !== e) begin
      n_fail++;
      $display("FAIL reset_status: got %h want %h", readdata, e);
    end
    address = 3'd0;
    rd_q.push_back(32'hA5);
    out_q.push_back(8'hA5);
    step();
    e  = rd_q.pop_front();
    eo = out_q.pop_front();
    n_tests++;
    if (readdata !== e) begin
      n_fail++;
      $display("FAIL reset_data: got %h want %h", readdata, e);
    end
    n_tests++;
    if (out_port !== eo) begin
      n_fail++;
      $display("FAIL reset_out_hold: got %h want %h", out_port, eo);
    end
  endtask

  task automatic test_set_clear();
    logic [2:0]  wa [3] = '{3'd0, 3'd4, 3'd5};
    logic [31:0] wd [3] = '{32'h0F, 32'h30, 32'h03};
    logic [7:0]  ex [3] = '{8'h0F, 8'h3F, 8'h3C};
    logic [7:0]  prev;
    logic [31:0] e;
    logic [7:0]  eo;
    prev = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      out_q.push_back(prev);
      write_reg(wa[i], wd[i]);
      eo = out_q.pop_front();
      n_tests++;
      if (out_port !== eo) begin
        n_fail++;
        $display("FAIL setclr_out_lag[%0d]: got %h want %h", i, out_port, eo);
      end
      address = 3'd0;
      rd_q.push_back({24'h0, ex[i]});
      out_q.push_back(ex[i]);
      step();
      e  = rd_q.pop_front();
      eo = out_q.pop_front();
      n_tests++;
      if (readdata !== e) begin
        n_fail++;
        $display("FAIL setclr_read[%0d]: got %h want %h", i, readdata, e);
      end
      n_tests++;
      if (out_port !== eo) begin
        n_fail++;
        $display("FAIL setclr_out[%0d]: got %h want %h", i, out_port, eo);
      end
      prev = ex[i];
    end
  endtask

  task automatic test_blink();
    logic [31:0] e;
    logic [7:0]  eo;
    logic        ph;
    write_reg(3'd0, 32'h01);
    write_reg(3'd1, 32'h01);
    write_reg(3'd2, 32'd3);
    // 4 cycles lit, 4 dark; status and out_port both lag phase by one edge
    for (int k = 1; k <= 14; k++) begin
      ph = (((k - 1) / 4) % 2) == 0;
      address = 3'd3;
      rd_q.push_back({31'h0, ph});
      out_q.push_back({7'h0, ph});
      step();
      e  = rd_q.pop_front();
      eo = out_q.pop_front();
      n_tests++;
      if (readdata !== e || out_port !== eo) begin
        n_fail++;
        $display("FAIL blink3[%0d]: status %h out %h want %h %h", k, readdata, out_port, e, eo);
      end
    end
    // phase is 0 here; the period write forces it back to 1
    out_q.push_back(8'h00);
    write_reg(3'd2, 32'd1);
    eo = out_q.pop_front();
    n_tests++;
    if (out_port !== eo) begin
      n_fail++;
      $display("FAIL blink_reload_lag: got %h want %h", out_port, eo);
    end
    for (int k = 1; k <= 8; k++) begin
      ph = (((k - 1) / 2) % 2) == 0;
      address = 3'd3;
      rd_q.push_back({31'h0, ph});
      out_q.push_back({7'h0, ph});
      step();
      e  = rd_q.pop_front();
      eo = out_q.pop_front();
      n_tests++;
      if (readdata !== e || out_port !== eo) begin
        n_fail++;
        $display("FAIL blink1[%0d]: status %h out %h want %h %h", k, readdata, out_port, e, eo);
      end
    end
    write_reg(3'd2, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      address = 3'd3;
      rd_q.push_back(32'h1);
      out_q.push_back(8'h01);
      step();
      e  = rd_q.pop_front();
      eo = out_q.pop_front();
      n_tests++;
      if (readdata !== e || out_port !== eo) begin
        n_fail++;
        $display("FAIL blink_off[%0d]: status %h out %h want %h %h", k, readdata, out_port, e, eo);
      end
    end
  endtask

  task automatic test_map();
    logic [31:0] e;
    logic [31:0] ex [8] = '{32'h5A, 32'hFF, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [2:0]  ign [3] = '{3'd3, 3'd6, 3'd7};
    write_reg(3'd0, 32'hFFFF_FFFF);
    address = 3'd0;
    rd_q.push_back(32'h0000_00FF);
    step();
    e = rd_q.pop_front();
    n_tests++;
    if (readdata !== e) begin
      n_fail++;
      $display("FAIL map_data_upper: got %h want %h", readdata, e);
    end
    write_reg(3'd2, 32'hFFFF_FFFF);
    address = 3'd2;
    rd_q.push_back(32'h00FF_FFFF);
    step();
    e = rd_q.pop_front();
    n_tests++;
    if (readdata !== e) begin
      n_fail++;
      $display("FAIL map_period_upper: got %h want %h", readdata, e);
    end
    write_reg(3'd2, 32'h0);
    write_reg(3'd1, 32'hFFFF_FFFF);
    write_reg(3'd0, 32'h5A);
    for (int i = 0; i < 3; i++) write_reg(ign[i], 32'hFFFF_FFFF);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      rd_q.push_back(ex[a]);
      step();
      e = rd_q.pop_front();
      n_tests++;
      if (readdata !== e) begin
        n_fail++;
        $display("FAIL map_read[%0d]: got %h want %h", a, readdata, e);
      end
    end
    n_tests++;
    if (out_port !== 8'h5A) begin
      n_fail++;
      $display("FAIL map_out: got %h want %h", out_port, 8'h5A);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] e;
    write_reg(3'd0, 32'hAA);
    rd_q.push_back(32'hAA);
    rd_q.push_back(32'h55);
    write_reg(3'd0, 32'h55);
    e = rd_q.pop_front();
    n_tests++;
    if (readdata !== e) begin
      n_fail++;
      $display("FAIL rdw_old: got %h want %h", readdata, e);
    end
    address = 3'd0;
    step();
    e = rd_q.pop_front();
    n_tests++;
    if (readdata !== e) begin
      n_fail++;
      $display("FAIL rdw_new: got %h want %h", readdata, e);
    end
    n_tests++;
    if (out_port !== 8'h55) begin
      n_fail++;
      $display("FAIL rdw_out: got %h want %h", out_port, 8'h55);
    end
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    repeat (2) step();
    reset = 1'b0;
    test_reset();
    test_set_clear();
    test_blink();
    test_map();
    test_read_during_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
